// File: rtl/axi4_lite_cfg_regbank.sv
// AXI4-Lite slave exposing NUM_REGS writable config words,
// one read-only status word and start / write strobes.
module axi4_lite_cfg_regbank #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 8
) (
   input  logic                     axi_aclk,
   input  logic                     axi_aresetn,
   input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
   input  logic                     S_AXI_AWVALID,
   output logic                     S_AXI_AWREADY,
   input  logic [31:0]              S_AXI_WDATA,
   input  logic [3:0]               S_AXI_WSTRB,
   input  logic                     S_AXI_WVALID,
   output logic                     S_AXI_WREADY,
   output logic [1:0]               S_AXI_BRESP,
   output logic                     S_AXI_BVALID,
   input  logic                     S_AXI_BREADY,
   input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
   input  logic                     S_AXI_ARVALID,
   output logic                     S_AXI_ARREADY,
   output logic [31:0]              S_AXI_RDATA,
   output logic [1:0]               S_AXI_RRESP,
   output logic                     S_AXI_RVALID,
   input  logic                     S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]   cfg_regs,
   output logic [NUM_REGS-1:0]      cfg_wr_pulse,
   input  logic [31:0]              status_in,
   output logic                     start_pulse
);

   localparam int IDX_W = ADDR_W - 2;
   localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(NUM_REGS);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t r_wstate, w_wnext;
   rstate_t r_rstate, w_rnext;

   logic                r_rdy;
   logic [IDX_W-1:0]    r_awidx;
   logic [31:0]         r_wdata;
   logic [3:0]          r_wstrb;
   logic [31:0]         r_regs [NUM_REGS];
   logic [1:0]          r_bresp;
   logic [31:0]         r_rdata;
   logic [1:0]          r_rresp;
   logic [NUM_REGS-1:0] r_wr_pulse;
   logic                r_start;

   logic             w_aw_hs, w_w_hs, w_ar_hs;
   logic [IDX_W-1:0] w_wr_idx, w_ar_idx;
   logic [31:0]      w_wr_data, w_wr_val;
   logic [3:0]       w_wr_strb;
   logic             w_do_wr, w_wr_ok;
   logic [31:0]      w_rd_data;
   logic [1:0]       w_rd_resp;

   // Ready outputs stay low until the first edge after reset release
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) r_rdy <= 1'b0;
      else              r_rdy <= 1'b1;
   end

   assign S_AXI_AWREADY = r_rdy &
      ((r_wstate == W_IDLE) | (r_wstate == W_DATA));
   assign S_AXI_WREADY  = r_rdy &
      ((r_wstate == W_IDLE) | (r_wstate == W_ADDR));
   assign S_AXI_BVALID  = (r_wstate == W_RESP);
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_rdy & (r_rstate == R_IDLE);
   assign S_AXI_RVALID  = (r_rstate == R_DATA);
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign cfg_wr_pulse  = r_wr_pulse;
   assign start_pulse   = r_start;

   assign w_aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_w_hs   = S_AXI_WVALID & S_AXI_WREADY;
   assign w_ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign w_ar_idx = S_AXI_ARADDR[ADDR_W-1:2];

   // Write FSM state register
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) r_wstate <= W_IDLE;
      else              r_wstate <= w_wnext;
   end

   // Write FSM next state; whichever half arrives last completes it
   always_comb begin
      w_wnext = r_wstate;
      unique case (r_wstate)
         W_IDLE: begin
            if (w_aw_hs && w_w_hs) w_wnext = W_RESP;
            else if (w_aw_hs)      w_wnext = W_ADDR;
            else if (w_w_hs)       w_wnext = W_DATA;
         end
         W_ADDR: if (w_w_hs)  w_wnext = W_RESP;
         W_DATA: if (w_aw_hs) w_wnext = W_RESP;
         W_RESP: if (S_AXI_BREADY) w_wnext = W_IDLE;
         default: w_wnext = W_IDLE;
      endcase
   end

   // Merge held and live halves of the write; reg0 bit 0 never stores
   always_comb begin
      w_wr_idx  = (r_wstate == W_ADDR) ? r_awidx
                                       : S_AXI_AWADDR[ADDR_W-1:2];
      w_wr_data = (r_wstate == W_DATA) ? r_wdata : S_AXI_WDATA;
      w_wr_strb = (r_wstate == W_DATA) ? r_wstrb : S_AXI_WSTRB;
      w_do_wr   = (r_wstate != W_RESP) && (w_wnext == W_RESP);
      w_wr_ok   = (w_wr_idx < STAT_IDX);
      w_wr_val  = w_wr_data;
      if (w_wr_idx == '0) w_wr_val[0] = 1'b0;
   end

   // Hold whichever write half was accepted first
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_awidx <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else begin
         if (w_aw_hs) r_awidx <= S_AXI_AWADDR[ADDR_W-1:2];
         if (w_w_hs) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
         end
      end
   end

   // Byte-lane register update on the edge entering W_RESP
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_do_wr && w_wr_ok) begin
         for (int i = 0; i < NUM_REGS; i++)
            if (w_wr_idx == IDX_W'(i))
               for (int b = 0; b < 4; b++)
                  if (w_wr_strb[b])
                     r_regs[i][8*b +: 8] <= w_wr_val[8*b +: 8];
      end
   end

   // Response code and one-cycle strobes aligned with BVALID rise
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_bresp    <= 2'b00;
         r_wr_pulse <= '0;
         r_start    <= 1'b0;
      end else begin
         r_wr_pulse <= '0;
         r_start    <= 1'b0;
         if (w_do_wr) begin
            r_bresp <= w_wr_ok ? 2'b00 : 2'b10;
            if (w_wr_ok) begin
               for (int i = 0; i < NUM_REGS; i++)
                  r_wr_pulse[i] <= (w_wr_idx == IDX_W'(i));
               r_start <= (w_wr_idx == '0) & w_wr_strb[0]
                          & w_wr_data[0];
            end
         end
      end
   end

   // Flatten register file onto the config bus
   always_comb begin
      cfg_regs = '0;
      for (int i = 0; i < NUM_REGS; i++)
         cfg_regs[32*i +: 32] = r_regs[i];
   end

   // Read decode: config, status or unmapped
   always_comb begin
      w_rd_data = '0;
      w_rd_resp = 2'b10;
      if (w_ar_idx == STAT_IDX) begin
         w_rd_data = status_in;
         w_rd_resp = 2'b00;
      end
      for (int i = 0; i < NUM_REGS; i++)
         if (w_ar_idx == IDX_W'(i)) begin
            w_rd_data = r_regs[i];
            w_rd_resp = 2'b00;
         end
   end

   // Read FSM state register
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) r_rstate <= R_IDLE;
      else              r_rstate <= w_rnext;
   end

   // Read FSM next state: one outstanding read
   always_comb begin
      w_rnext = r_rstate;
      unique case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
         R_DATA:  if (S_AXI_RREADY) w_rnext = R_IDLE;
         default: w_rnext = R_IDLE;
      endcase
   end

   // Capture read data at AR handshake; held until accepted
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_rdata <= '0;
         r_rresp <= 2'b00;
      end else if (w_ar_hs) begin
         r_rdata <= w_rd_data;
         r_rresp <= w_rd_resp;
      end
   end

endmodule

// File: tb/tb_axi4_lite_cfg_regbank.sv
// Scenario bench for axi4_lite_cfg_regbank: model-driven
// expected responses queued at issue, compared at completion.
module tb_axi4_lite_cfg_regbank;

   localparam int NR = 8;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0]    awaddr, araddr;
   logic             awvalid, awready, wvalid, wready;
   logic [31:0]      wdata, rdata, status;
   logic [3:0]       wstrb;
   logic [1:0]       bresp, rresp;
   logic             bvalid, bready, arvalid, arready;
   logic             rvalid, rready, start;
   logic [NR*32-1:0] cfg;
   logic [NR-1:0]    wpulse;

   axi4_lite_cfg_regbank #(.NUM_REGS(NR), .ADDR_W(AW)) dut (
      .axi_aclk(clk), .axi_aresetn(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
      .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
      .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .cfg_regs(cfg), .cfg_wr_pulse(wpulse),
      .status_in(status), .start_pulse(start)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] m_regs [NR];
   logic [1:0]  q_b [$];
   logic [33:0] q_r [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_write(input logic [7:0] a,
                                       input logic [31:0] d,
                                       input logic [3:0] s);
      int idx;
      idx = int'(a[7:2]);
      if (idx < NR) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
         m_regs[0][0] = 1'b0;
         q_b.push_back(2'b00);
      end else begin
         q_b.push_back(2'b10);
      end
   endfunction

   function automatic void model_read(input logic [7:0] a);
      int idx;
      idx = int'(a[7:2]);
      if (idx < NR)       q_r.push_back({2'b00, m_regs[idx]});
      else if (idx == NR) q_r.push_back({2'b00, status});
      else                q_r.push_back({2'b10, 32'h0});
   endfunction

   function automatic logic [NR*32-1:0] model_flat();
      logic [NR*32-1:0] f;
      for (int i = 0; i < NR; i++) f[32*i +: 32] = m_regs[i];
      return f;
   endfunction

   // W presented first, AW follows w_lead cycles later (0 = same cycle)
   task automatic send_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int w_lead,
                             input string nm);
      bit aw_done = 0, w_done = 0, aw_ok, w_ok;
      int c = 0;
      model_write(a, d, s);
      awaddr = a; wdata = d; wstrb = s;
      wvalid = 1'b1;
      awvalid = (w_lead == 0);
      while (!(aw_done && w_done) && c < 20) begin
         aw_ok = awvalid && awready;
         w_ok  = wvalid && wready;
         tick();
         c++;
         if (aw_ok) begin awvalid = 1'b0; aw_done = 1; end
         if (w_ok)  begin wvalid = 1'b0;  w_done = 1;  end
         if (c == w_lead && !aw_done) awvalid = 1'b1;
      end
      if (!(aw_done && w_done)) begin
         n_tests++; n_fail++;
         $display("FAIL %s: write handshake timeout", nm);
         awvalid = 1'b0; wvalid = 1'b0;
      end
   endtask

   task automatic collect_b(input string nm);
      int c = 0;
      logic [1:0] exp;
      while (!bvalid && c < 20) begin tick(); c++; end
      n_tests++;
      if (!bvalid || q_b.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no BVALID (got %b, q=%0d)", nm, bvalid,
                  q_b.size());
         return;
      end
      exp = q_b.pop_front();
      bready = 1'b1;
      if (bresp !== exp) begin
         n_fail++;
         $display("FAIL %s bresp: got %b want %b", nm, bresp, exp);
      end
      tick();
      bready = 1'b0;
      n_tests++;
      if (bvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s bvalid drop: got %b want 0", nm, bvalid);
      end
   endtask

   task automatic send_ar(input logic [7:0] a, input string nm);
      int c = 0;
      araddr = a;
      arvalid = 1'b1;
      while (!arready && c < 20) begin tick(); c++; end
      if (!arready) begin
         n_tests++; n_fail++;
         $display("FAIL %s: ARREADY timeout", nm);
         arvalid = 1'b0;
         return;
      end
      model_read(a);
      tick();
      arvalid = 1'b0;
   endtask

   task automatic collect_r(input int stall, input string nm);
      int c = 0;
      bit bad = 0;
      logic [31:0] d0;
      logic [33:0] exp;
      while (!rvalid && c < 20) begin tick(); c++; end
      n_tests++;
      if (!rvalid || q_r.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no RVALID (got %b, q=%0d)", nm, rvalid,
                  q_r.size());
         return;
      end
      exp = q_r.pop_front();
      d0 = rdata;
      for (int i = 0; i < stall; i++) begin
         tick();
         if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0)
            bad = 1;
      end
      if (stall > 0) begin
         n_tests++;
         if (bad) begin
            n_fail++;
            $display("FAIL %s stall hold: rv=%b rd=%h ar=%b want 1 %h 0",
                     nm, rvalid, rdata, arready, d0);
         end
      end
      rready = 1'b1;
      n_tests++;
      if ({rresp, rdata} !== exp) begin
         n_fail++;
         $display("FAIL %s rdata: got %b/%h want %b/%h", nm, rresp,
                  rdata, exp[33:32], exp[31:0]);
      end
      tick();
      rready = 1'b0;
      n_tests++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s read end: rv=%b ar=%b want 0 1", nm,
                  rvalid, arready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({awready, wready, arready, bvalid, rvalid, start} !== 6'b0
          || cfg !== '0 || wpulse !== '0) begin
         n_fail++;
         $display("FAIL reset state: rdy=%b%b%b bv=%b rv=%b cfg=%h",
                  awready, wready, arready, bvalid, rvalid, cfg);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_tests++;
      if ({awready, wready, arready} !== 3'b000) begin
         n_fail++;
         $display("FAIL ready before edge: got %b%b%b want 000",
                  awready, wready, arready);
      end
      tick();
      n_tests++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_fail++;
         $display("FAIL ready after edge: got %b%b%b want 111",
                  awready, wready, arready);
      end
   endtask

   task automatic test_write_same_cycle();
      send_write(8'h04, 32'hDEADBEEF, 4'hF, 0, "wr_same");
      n_tests++;
      if (bvalid !== 1'b1 || wpulse !== 8'h02 || start !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_same pulse: bv=%b wp=%h st=%b want 1 02 0",
                  bvalid, wpulse, start);
      end
      collect_b("wr_same");
      n_tests++;
      if (cfg[63:32] !== 32'hDEADBEEF || wpulse !== 8'h00) begin
         n_fail++;
         $display("FAIL wr_same reg1: got %h wp=%h want deadbeef 00",
                  cfg[63:32], wpulse);
      end
   endtask

   task automatic test_w_first();
      send_write(8'h08, 32'h11223344, 4'hF, 0, "preset2");
      collect_b("preset2");
      send_write(8'h08, 32'h000000AA, 4'h1, 3, "w_first");
      n_tests++;
      if (bvalid !== 1'b1 || wpulse !== 8'h04) begin
         n_fail++;
         $display("FAIL w_first pulse: bv=%b wp=%h want 1 04",
                  bvalid, wpulse);
      end
      collect_b("w_first");
      n_tests++;
      if (cfg[95:64] !== 32'h112233AA || cfg !== model_flat()) begin
         n_fail++;
         $display("FAIL w_first reg2: got %h want 112233aa",
                  cfg[95:64]);
      end
   endtask

   task automatic test_start_and_status();
      send_write(8'h00, 32'h00000003, 4'hF, 0, "start");
      n_tests++;
      if (start !== 1'b1 || wpulse !== 8'h01) begin
         n_fail++;
         $display("FAIL start pulse: st=%b wp=%h want 1 01", start,
                  wpulse);
      end
      collect_b("start");
      n_tests++;
      if (start !== 1'b0 || cfg[31:0] !== 32'h00000002) begin
         n_fail++;
         $display("FAIL start after: st=%b reg0=%h want 0 00000002",
                  start, cfg[31:0]);
      end
      send_ar(8'h00, "rd_reg0");
      collect_r(0, "rd_reg0");
      send_write(8'h20, 32'hFFFFFFFF, 4'hF, 0, "wr_status");
      n_tests++;
      if (wpulse !== 8'h00 || start !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_status pulse: wp=%h st=%b want 00 0",
                  wpulse, start);
      end
      collect_b("wr_status");
      n_tests++;
      if (cfg !== model_flat()) begin
         n_fail++;
         $display("FAIL wr_status regs: got %h want %h", cfg,
                  model_flat());
      end
   endtask

   task automatic test_read_stall();
      send_write(8'h0C, 32'h0BADCAFE, 4'hF, 0, "preset3");
      collect_b("preset3");
      send_ar(8'h0C, "rd_stall");
      collect_r(5, "rd_stall");
      send_ar(8'h30, "rd_unmap");
      collect_r(0, "rd_unmap");
   endtask

   task automatic test_bready_stall();
      status = 32'hCAFEF00D;
      send_write(8'h10, 32'h55AA55AA, 4'hF, 0, "bstall");
      send_ar(8'h20, "rd_status");
      collect_r(2, "rd_status");
      n_tests++;
      if (bvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL bstall bvalid: got %b want 1", bvalid);
      end
      collect_b("bstall");
   endtask

   task automatic test_back_to_back();
      send_write(8'h14, 32'h12345678, 4'hF, 0, "preset5");
      collect_b("preset5");
      awaddr = 8'h14; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
      araddr = 8'h14;
      model_read(8'h14);
      model_write(8'h14, 32'hA5A5A5A5, 4'hF);
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      collect_r(0, "rw_same_rd");
      collect_b("rw_same_wr");
      send_ar(8'h14, "rd_after");
      collect_r(0, "rd_after");
      send_write(8'h14, 32'hFFFFFFFF, 4'h0, 0, "strb0");
      n_tests++;
      if (wpulse !== 8'h20) begin
         n_fail++;
         $display("FAIL strb0 pulse: got %h want 20", wpulse);
      end
      collect_b("strb0");
      n_tests++;
      if (cfg[191:160] !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL strb0 reg5: got %h want a5a5a5a5",
                  cfg[191:160]);
      end
   endtask

   task automatic test_reset_mid();
      awaddr = 8'h04; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (cfg !== '0 || bvalid !== 1'b0 || rdata !== 32'h0 ||
          {awready, wready, arready} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_mid async: cfg=%h bv=%b rd=%h rdy=%b%b%b",
                  cfg, bvalid, rdata, awready, wready, arready);
      end
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      n_tests++;
      if (bvalid !== 1'b0 || cfg[63:32] !== 32'h0 || wpulse !== '0 ||
          {awready, wready} !== 2'b11) begin
         n_fail++;
         $display("FAIL rst_mid after: bv=%b reg1=%h wp=%h rdy=%b%b",
                  bvalid, cfg[63:32], wpulse, awready, wready);
      end
   endtask

   initial begin
      awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
      bready = 0; araddr = '0; arvalid = 0; rready = 0;
      status = 32'h0;
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      test_reset();
      test_write_same_cycle();
      test_w_first();
      test_start_and_status();
      test_read_stall();
      test_bready_stall();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi4_lite_cfg_regbank.md
AXI4_LITE_CFG_REGBANK -- requirements
Module: axi4_lite_cfg_regbank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of writable 32-bit config registers (legal 1..64).
REQ-002 SHALL have parameter ADDR_W, default 8, AXI address width (requires 2^(ADDR_W-2) > NUM_REGS).
REQ-003 SHALL have port axi_aclk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port axi_aresetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports S_AXI_AWADDR input ADDR_W, S_AXI_AWVALID input 1, S_AXI_AWREADY output 1: write address channel.
REQ-006 SHALL have ports S_AXI_WDATA input 32, S_AXI_WSTRB input 4, S_AXI_WVALID input 1, S_AXI_WREADY output 1: write data channel.
REQ-007 SHALL have ports S_AXI_BRESP output 2, S_AXI_BVALID output 1, S_AXI_BREADY input 1: write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR input ADDR_W, S_AXI_ARVALID input 1, S_AXI_ARREADY output 1: read address channel.
REQ-009 SHALL have ports S_AXI_RDATA output 32, S_AXI_RRESP output 2, S_AXI_RVALID output 1, S_AXI_RREADY input 1: read data channel.
REQ-010 SHALL have port cfg_regs  output  NUM_REGS*32  flat register contents, reg i at bits [32*i+31:32*i].
REQ-011 SHALL have port cfg_wr_pulse  output  NUM_REGS  one-cycle strobe, bit i high in the cycle after reg i is written.
REQ-012 SHALL have port status_in  input  32  read-only status word from datapath.
REQ-013 SHALL have port start_pulse  output  1  one-cycle start command.

Function
REQ-014 Address decode SHALL use idx = ADDR[ADDR_W-1:2]; ADDR[1:0] ignored; idx<NUM_REGS = config reg, idx==NUM_REGS = status (RO), idx>NUM_REGS = unmapped.
REQ-015 Write FSM SHALL have states W_IDLE, W_ADDR (address held), W_DATA (data held), W_RESP.
REQ-016 AWREADY SHALL be 1 exactly in W_IDLE and W_DATA; WREADY exactly in W_IDLE and W_ADDR; both 0 in W_RESP.
REQ-017 W_IDLE: AW-only handshake -> W_ADDR; W-only -> W_DATA; both same cycle -> W_RESP; W_ADDR/W_DATA complete on missing handshake -> W_RESP.
REQ-018 Register update SHALL occur on the edge entering W_RESP, byte lane b updated only where WSTRB[b]=1; BVALID=1 from that cycle until BVALID&BREADY, then W_IDLE.
REQ-019 BRESP SHALL be 2'b00 for config regs, 2'b10 (SLVERR) for status or unmapped; SLVERR writes SHALL change no state and raise no pulse.
REQ-020 Write to reg 0 with WSTRB[0]=1 and WDATA[0]=1 SHALL raise start_pulse for one cycle concurrent with BVALID rise; reg0 bit 0 SHALL always store and read 0.
REQ-021 cfg_wr_pulse[i] SHALL assert for one cycle concurrent with BVALID rise for any OKAY write to reg i, including WSTRB=0.
REQ-022 Read FSM SHALL have states R_IDLE (ARREADY=1, RVALID=0) and R_DATA (ARREADY=0, RVALID=1); one outstanding read.
REQ-023 ARVALID in R_IDLE SHALL move to R_DATA next cycle with RDATA/RRESP registered from the address sampled at handshake; latency 1 cycle.
REQ-024 RDATA/RRESP SHALL hold stable while RVALID&!RREADY; RVALID&RREADY returns to R_IDLE; next ARREADY one cycle later.
REQ-025 Read of status SHALL return status_in sampled at AR handshake, RRESP 2'b00; unmapped SHALL return 32'h0, RRESP 2'b10.
REQ-026 Read and write FSMs SHALL be independent; read handshake in same cycle as write update to same reg SHALL return pre-write value.
REQ-027 Master stalling BREADY or RREADY indefinitely SHALL block only its own channel.

Reset
REQ-028 axi_aresetn low SHALL immediately (asynchronously) force W_IDLE, R_IDLE, all cfg regs 0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, start_pulse=0, cfg_wr_pulse=0.
REQ-029 AWREADY, WREADY, ARREADY SHALL be 0 while reset is asserted and go 1 on the first edge after deassertion.
REQ-030 Reset mid-transaction SHALL abandon it with no register update and no pulse.

Verification
REQ-031 AW 0x04 + W 0xDEADBEEF/STRB 0xF same cycle -> BVALID next cycle, BRESP 00, reg1=0xDEADBEEF, cfg_wr_pulse[1] one cycle.
REQ-032 W first (0x000000AA, STRB 0x1), AW 0x08 three cycles later, reg2 preset 0x11223344 -> reg2=0x112233AA, BRESP 00.
REQ-033 Write 0x00000003 to 0x00 -> start_pulse one cycle, reg0 reads 0x00000002; write 0x20 (NUM_REGS=8, status) -> BRESP 10, no change.
REQ-034 Read 0x0C with RREADY low 5 cycles -> RVALID held, RDATA stable = reg3, ARREADY 0 throughout; read 0x30 -> RDATA 0, RRESP 10.
REQ-035 BREADY held low while read of status_in=0xCAFEF00D proceeds -> RDATA 0xCAFEF00D, RRESP 00, BVALID still 1.
REQ-036 axi_aresetn low during W_ADDR after AW 0x04 -> outputs cleared asynchronously, reg1 unchanged 0, no BVALID after release.
